nibble_serial_sub_ctrl: RTL and testbench

Sequencer that time-multiplexes one 4-bit borrow-chained subtract slice to subtract two WIDTH-bit operands, one nibble per clock, LSB nibble first.
- Borrow is carried between cycles in a register.
- Valid/ready handshake on both input and output; the result is held until consumed.
- Sits between operand producers and any consumer of wide differences where area matters more than latency.

---
 rtl/nibble_sub_pkg.sv | 12 +
 rtl/nibble_sub_slice.sv | 23 ++
 rtl/nibble_serial_sub_ctrl.sv | 138 +++++++++++++
 tb/tb_nibble_serial_sub_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package nibble_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_sub_slice.sv
// Combinational 4-bit subtract slice: ripple of full-subtract cells, {bo,d} = a - b - bin.
module nibble_sub_slice
    import nibble_sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                bin,
    output logic [NIBBLE_W-1:0] d,
    output logic                bo
);

    logic [NIBBLE_W:0] br;

    assign br[0] = bin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_cell
        assign d[i]    = a[i] ^ b[i] ^ br[i];
        assign br[i+1] = (~a[i] & b[i]) | (~a[i] & br[i]) | (b[i] & br[i]);
    end

    assign bo = br[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_sub_ctrl.sv
// Nibble-serial WIDTH-bit subtractor: one shared 4-bit slice, LSB nibble first, valid/ready on both sides.
// Optional zero flag output enabled by defining NIBBLE_SERIAL_SUB_ZERO_FLAG_EN.
module nibble_serial_sub_ctrl
    import nibble_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;

    logic [NIBBLE_W-1:0] sl_a, sl_b, sl_d;
    logic                sl_bo;
    int                  sel;

    assign sel  = int'(idx_q) * NIBBLE_W;
    assign sl_a = a_q[sel +: NIBBLE_W];
    assign sl_b = b_q[sel +: NIBBLE_W];

    nibble_sub_slice u_slice (
        .a   (sl_a),
        .b   (sl_b),
        .bin (borrow_q),
        .d   (sl_d),
        .bo  (sl_bo)
    );

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
    end

    // Previous diff stays visible in IDLE; it is overwritten nibble by nibble once RUN starts.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        idx_d    = idx_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    idx_d    = '0;
                end
            end
            RUN: begin
                diff_d[sel +: NIBBLE_W] = sl_d;
                borrow_d                = sl_bo;
                if (idx_q == LAST_IDX) bout_d = sl_bo;
                else                   idx_d  = idx_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    assign diff = diff_q;
    assign bout = bout_q;

`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
    logic zero_q, zero_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) zero_q <= 1'b0;
        else        zero_q <= zero_d;
    end

    always_comb begin
        zero_d = zero_q;
        if (state_q == IDLE && in_valid) zero_d = 1'b1;
        else if (state_q == RUN)         zero_d = zero_q & (sl_d == '0);
    end

    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Self-checking bench for nibble_serial_sub_ctrl (WIDTH=16 main instance plus a WIDTH=4 instance).
module tb_nibble_serial_sub_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, bin, out_valid, out_ready, bout, busy;
    logic [W-1:0] a, b, diff;

    logic         s_in_valid, s_in_ready, s_bin, s_out_valid, s_out_ready, s_bout, s_busy;
    logic [3:0]   s_a, s_b, s_diff;

`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
    logic zero, s_zero;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .busy(busy)
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    nibble_serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .bin(s_bin), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .diff(s_diff), .bout(s_bout), .busy(s_busy)
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
        , .zero(s_zero)
`endif
    );

    // Reference: plain unsigned arithmetic on wide integers.
    function automatic void model(input longint unsigned xa, input longint unsigned xb,
                                  input logic xbin, input int w,
                                  output longint unsigned d, output logic bo);
        longint unsigned m;
        m  = (64'd1 << w) - 1;
        d  = (xa - xb - longint'(xbin)) & m;
        bo = (xa < xb + longint'(xbin));
    endfunction

    // Present operands, accept, scramble inputs, then wait for out_valid; returns latency and in_ready abuse.
    task automatic start_and_wait(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                                  output int lat, output logic rdy_bad);
        @(negedge clk);
        a = xa; b = xb; bin = xbin; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        lat = 0; rdy_bad = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin, input string nm);
        int lat; logic rdy_bad; longint unsigned ed; logic eb;
        model(xa, xb, xbin, W, ed, eb);
        start_and_wait(xa, xb, xbin, lat, rdy_bad);
        checks++; if (lat !== NIB) begin failures++; $display("FAIL %s latency: got %0d want %0d", nm, lat, NIB); end
        checks++; if (rdy_bad !== 1'b0) begin failures++; $display("FAIL %s in_ready high while busy", nm); end
        checks++; if (diff !== W'(ed)) begin failures++; $display("FAIL %s diff: got %h want %h", nm, diff, W'(ed)); end
        checks++; if (bout !== eb) begin failures++; $display("FAIL %s bout: got %b want %b", nm, bout, eb); end
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
        checks++; if (zero !== (ed == 0)) begin failures++; $display("FAIL %s zero: got %b want %b", nm, zero, ed == 0); end
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL %s return to idle: in_ready=%b out_valid=%b busy=%b want 1 0 0", nm, in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_bin = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
            failures++; $display("FAIL reset_state: out_valid=%b busy=%b diff=%h bout=%b want 0 0 0000 0", out_valid, busy, diff, bout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h0034, 1'b0, "basic");
        run_op(16'h1000, 16'h0001, 1'b0, "borrow_chain");
        run_op(16'h0000, 16'h0001, 1'b0, "underflow");
        run_op(16'h5A5A, 16'h5A5A, 1'b1, "eq_bin1");
        run_op(16'h5A5A, 16'h5A5A, 1'b0, "eq_bin0");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, "max_bin1");
        run_op(16'h0000, 16'hFFFF, 1'b1, "min_minus_max");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), "random");
    endtask

    task automatic test_backpressure();
        int lat; logic rdy_bad; longint unsigned ed; logic eb;
        model(64'hBEEF, 64'h1234, 1'b1, W, ed, eb);
        start_and_wait(16'hBEEF, 16'h1234, 1'b1, lat, rdy_bad);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== W'(ed) || bout !== eb) begin
                failures++;
                $display("FAIL backpressure hold: out_valid=%b in_ready=%b diff=%h bout=%b want 1 0 %h %b",
                         out_valid, in_ready, diff, bout, W'(ed), eb);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== W'(ed)) begin
            failures++; $display("FAIL backpressure release: in_ready=%b out_valid=%b diff=%h want 1 0 %h", in_ready, out_valid, diff, W'(ed));
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic rdy_bad;
        // Abort after the second RUN cycle.
        @(negedge clk);
        a = 16'h8765; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || diff !== '0) begin
            failures++; $display("FAIL reset_mid_run: out_valid=%b busy=%b diff=%h want 0 0 0000", out_valid, busy, diff);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h4321, 16'h0321, 1'b0, "after_reset_run");
        // Abort while DONE is held by backpressure.
        start_and_wait(16'h00F0, 16'h000F, 1'b0, lat, rdy_bad);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
            failures++; $display("FAIL reset_mid_done: out_valid=%b busy=%b diff=%h bout=%b want 0 0 0000 0", out_valid, busy, diff, bout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0001, 16'h0002, 1'b0, "after_reset_done");
    endtask

    task automatic test_back_to_back();
        longint unsigned qd[$];
        logic            qb[$];
        int              acc_cyc[$];
        int              n_acc = 0;
        int              guard = 0;
        longint unsigned ed; logic eb; logic [W-1:0] xa, xb; logic xbin;
        out_ready = 1'b1;
        @(negedge clk);
        while ((n_acc < 6 || qd.size() != 0) && guard < 200) begin
            if (out_valid) begin
                if (qd.size() == 0) begin
                    checks++; failures++; $display("FAIL b2b unexpected result diff=%h", diff);
                end else begin
                    ed = qd.pop_front(); eb = qb.pop_front();
                    checks++; if (diff !== W'(ed)) begin failures++; $display("FAIL b2b diff: got %h want %h", diff, W'(ed)); end
                    checks++; if (bout !== eb) begin failures++; $display("FAIL b2b bout: got %b want %b", bout, eb); end
`ifdef NIBBLE_SERIAL_SUB_ZERO_FLAG_EN
                    checks++; if (zero !== (ed == 0)) begin failures++; $display("FAIL b2b zero: got %b want %b", zero, ed == 0); end
`endif
                end
            end
            if (in_ready) begin
                if (n_acc < 6) begin
                    xa = W'($urandom); xb = W'($urandom); xbin = 1'($urandom);
                    a = xa; b = xb; bin = xbin; in_valid = 1'b1;
                    model(xa, xb, xbin, W, ed, eb);
                    qd.push_back(ed); qb.push_back(eb);
                    acc_cyc.push_back(cyc);
                    if (n_acc > 0) begin
                        checks++;
                        if (acc_cyc[n_acc] - acc_cyc[n_acc-1] !== NIB + 2) begin
                            failures++; $display("FAIL b2b spacing: got %0d want %0d", acc_cyc[n_acc] - acc_cyc[n_acc-1], NIB + 2);
                        end
                    end
                    n_acc++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            guard++;
        end
        checks++; if (guard >= 200) begin failures++; $display("FAIL b2b timeout: pending %0d", qd.size()); end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_width4();
        logic [3:0] xa [4];
        logic [3:0] xb [4];
        logic       xc [4];
        longint unsigned ed; logic eb; int lat;
        xa[0] = 4'h3; xb[0] = 4'h5; xc[0] = 1'b0;
        xa[1] = 4'h7; xb[1] = 4'h7; xc[1] = 1'b1;
        xa[2] = 4'($urandom); xb[2] = 4'($urandom); xc[2] = 1'($urandom);
        xa[3] = 4'hF; xb[3] = 4'h0; xc[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            model(longint'(xa[i]), longint'(xb[i]), xc[i], 4, ed, eb);
            @(negedge clk);
            s_a = xa[i]; s_b = xb[i]; s_bin = xc[i]; s_in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            s_in_valid = 1'b0;
            lat = 0;
            while (!s_out_valid && lat < 20) begin @(negedge clk); lat++; end
            checks++; if (lat !== 1) begin failures++; $display("FAIL w4 latency: got %0d want 1", lat); end
            checks++;
            if (s_diff !== 4'(ed) || s_bout !== eb) begin
                failures++; $display("FAIL w4 result: got diff=%h bout=%b want %h %b", s_diff, s_bout, 4'(ed), eb);
            end
            s_out_ready = 1'b1;
            @(negedge clk);
            s_out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_width4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
